// File: rtl/cpu_pkg.sv
// Shared types for the CSC244 register-file controller.
// Opcodes, ALU encodings, FSM states and IR field positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_LOAD = 4'd0,
    OP_COPY = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_INV  = 4'd4,
    OP_FLIP = 4'd5
  } opcode_e;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_INV  = 2'b10;
  localparam logic [1:0] ALU_FLIP = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    C_LOAD = 2'd0,
    C_COPY = 2'd1,
    C_ALU  = 2'd2,
    C_ILL  = 2'd3
  } iclass_e;

  localparam int IR_W  = 10;
  localparam int RX_HI = 9;
  localparam int RX_LO = 8;
  localparam int RY_HI = 7;
  localparam int RY_LO = 6;
  localparam int OP_LO = 0;

endpackage

// File: rtl/instr_decode.sv
// Combinational IR decoder for reg_ctrl_fsm.
// Splits the IR into register fields, class and ALU op.
module instr_decode
  import cpu_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [IR_W-1:0] ir,
  output logic [1:0]      rx,
  output logic [1:0]      ry,
  output iclass_e         cls,
  output logic [1:0]      aluop
);

  logic [OPW-1:0] op;
  logic           unused_bits;

  assign op          = ir[OP_LO+OPW-1:OP_LO];
  assign unused_bits = ^ir[5:4];

  // Opcode to class and ALU function
  always_comb begin
    rx    = ir[RX_HI:RX_LO];
    ry    = ir[RY_HI:RY_LO];
    cls   = C_ILL;
    aluop = ALU_ADD;
    unique case (1'b1)
      (op == OPW'(OP_LOAD)): cls = C_LOAD;
      (op == OPW'(OP_COPY)): cls = C_COPY;
      (op == OPW'(OP_ADD)): begin
        cls   = C_ALU;
        aluop = ALU_ADD;
      end
      (op == OPW'(OP_SUB)): begin
        cls   = C_ALU;
        aluop = ALU_SUB;
      end
      (op == OPW'(OP_INV)): begin
        cls   = C_ALU;
        aluop = ALU_INV;
      end
      (op == OPW'(OP_FLIP)): begin
        cls   = C_ALU;
        aluop = ALU_FLIP;
      end
      default: cls = C_ILL;
    endcase
  end

endmodule

// File: rtl/reg_ctrl_fsm.sv
// Multi-cycle register-file controller (IDLE/T1/T2).
// Define REG_CTRL_TRAP_EN to add the sticky Err port.
module reg_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic            CLKb,
  input  logic            RSTb,
  input  logic            Execute,
  input  logic [IR_W-1:0] IR,
  output logic            ENW,
  output logic [1:0]      WRA,
  output logic            ENR0,
  output logic [1:0]      RDA0,
  output logic            ENR1,
  output logic [1:0]      RDA1,
  output logic            ExtEn,
  output logic            GLd,
  output logic            GEn,
  output logic [1:0]      AluOp,
  output logic            Busy,
  output logic            Done
`ifdef REG_CTRL_TRAP_EN
  ,
  output logic            Err
`endif
);

  state_e          state;
  logic [IR_W-1:0] ir_q;
  logic            ex_prev;
  logic [IR_W-1:0] dec_ir;
  logic [1:0]      d_rx;
  logic [1:0]      d_ry;
  iclass_e         d_cls;
  logic [1:0]      d_alu;
  logic            start;

  // In IDLE decode the incoming word so T1 outputs can be registered
  assign dec_ir = (state == S_IDLE) ? IR : ir_q;
  assign start  = (state == S_IDLE) && Execute && !ex_prev;

  instr_decode #(
    .OPW(OPW)
  ) u_dec (
    .ir   (dec_ir),
    .rx   (d_rx),
    .ry   (d_ry),
    .cls  (d_cls),
    .aluop(d_alu)
  );

  // State, IR latch, edge detector and registered Moore outputs
  always_ff @(posedge CLKb) begin
    if (!RSTb) begin
      state   <= S_IDLE;
      ir_q    <= '0;
      ex_prev <= 1'b1;
      ENW     <= 1'b0;
      WRA     <= 2'd0;
      ENR0    <= 1'b0;
      RDA0    <= 2'd0;
      ENR1    <= 1'b0;
      RDA1    <= 2'd0;
      ExtEn   <= 1'b0;
      GLd     <= 1'b0;
      GEn     <= 1'b0;
      AluOp   <= 2'd0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
`ifdef REG_CTRL_TRAP_EN
      Err     <= 1'b0;
`endif
    end else begin
      ex_prev <= Execute;
      ENW     <= 1'b0;
      WRA     <= 2'd0;
      ENR0    <= 1'b0;
      RDA0    <= 2'd0;
      ENR1    <= 1'b0;
      RDA1    <= 2'd0;
      ExtEn   <= 1'b0;
      GLd     <= 1'b0;
      GEn     <= 1'b0;
      AluOp   <= 2'd0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            ir_q  <= IR;
            state <= S_T1;
            Busy  <= 1'b1;
`ifdef REG_CTRL_TRAP_EN
            Err   <= (d_cls == C_ILL);
`endif
            unique case (d_cls)
              C_LOAD: begin
                ExtEn <= 1'b1;
                ENW   <= 1'b1;
                WRA   <= d_rx;
                Done  <= 1'b1;
              end
              C_COPY: begin
                ENR0 <= 1'b1;
                RDA0 <= d_ry;
                ENW  <= 1'b1;
                WRA  <= d_rx;
                Done <= 1'b1;
              end
              C_ALU: begin
                ENR1  <= 1'b1;
                RDA1  <= d_rx;
                ENR0  <= 1'b1;
                RDA0  <= d_ry;
                AluOp <= d_alu;
                GLd   <= 1'b1;
              end
              default: Done <= 1'b1;
            endcase
          end
        end
        S_T1: begin
          if (d_cls == C_ALU) begin
            state <= S_T2;
            Busy  <= 1'b1;
            GEn   <= 1'b1;
            ENW   <= 1'b1;
            WRA   <= d_rx;
            Done  <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/reg_ctrl_fsm.md
# reg_ctrl_fsm

Multi-cycle control unit sitting directly upstream of the 4 × 10-bit register file in the CSC244 datapath. It accepts an instruction word on a rising edge of `Execute` and sequences one instruction to completion. It drives the register file's write/read enables and addresses, the bus-source selects (external data, ALU result register G) and the ALU controls, then pulses `Done`.

## Interface
- `OPW`, default 4: opcode field width (IR[3:0]).
- `CLKb` in 1: system clock. All controller state updates on the rising edge; the register file captures on the following falling edge.
- `RSTb` in 1: synchronous active-low reset, sampled on the rising edge of `CLKb`.
- `Execute` in 1: start request, rising-edge detected.
- `IR` in 10: instruction; IR[9:8]=Rx, IR[7:6]=Ry, IR[5:4] ignored, IR[3:0]=opcode.
- `ENW`, `WRA` out 1/2: register-file write enable and address.
- `ENR0`, `RDA0` out 1/2: read port 0 (drives bus) enable and address.
- `ENR1`, `RDA1` out 1/2: read port 1 (ALU operand A) enable and address.
- `ExtEn` out 1: external data drives bus.
- `GLd` out 1: ALU result register G load.
- `GEn` out 1: G drives bus.
- `AluOp` out 2: 00 ADD, 01 SUB, 10 INV, 11 FLIP.
- `Busy` out 1: high in every non-IDLE state.
- `Done` out 1: one-cycle completion pulse.
- `Err` out 1: present only with `REG_CTRL_TRAP_EN`.

## Operation
- Opcodes: 0000 LOAD Rx←ext; 0001 COPY Rx←Ry; 0010 ADD Rx←Rx+Ry; 0011 SUB Rx←Rx−Ry; 0100 INV Rx←~Ry; 0101 FLIP Rx←bit-reverse(Ry); 0110–1111 illegal.
- Start detection: `ExPrev` register is reset to 1. A start occurs when `Execute`=1 and `ExPrev`=0 in IDLE. Holding `Execute` high through reset does not start an instruction.
- IR is latched into an internal register on the start edge. Later changes to `IR` have no effect until the next start.
- States: IDLE, T1, T2 (moore outputs).
  - IDLE: all outputs 0, `Busy`=0. On start, go to T1.
  - T1, LOAD: `ExtEn`, `ENW`, `WRA`=Rx, `Done`. Go to IDLE.
  - T1, COPY: `ENR0`, `RDA0`=Ry, `ENW`, `WRA`=Rx, `Done`. Go to IDLE.
  - T1, ALU ops: `ENR1`, `RDA1`=Rx, `ENR0`, `RDA0`=Ry, `AluOp` per opcode, `GLd`. Go to T2.
  - T2: `GEn`, `ENW`, `WRA`=Rx, `Done`. Go to IDLE.
  - T1, illegal opcode: `Done` only, no enables. Go to IDLE.
- Unused address outputs are 0 whenever their enable is 0.
- Rx=Ry is legal. For SUB, G=0 is written.
- `Execute` edges while `Busy` are ignored. `ExPrev` still tracks them, so a level still high on return to IDLE does not restart.

## Timing
- Reset: state IDLE; every output 0; internal IR register 0; `ExPrev`=1; `Err`=0. Reset takes effect on the next rising edge and overrides everything, including mid-T1/T2. No write is issued on the reset edge.
- Latency from the start edge to `Done`:
  - LOAD, COPY and illegal opcodes: 1 cycle.
  - ALU ops: 2 cycles.
- `ENW` and `Done` are coincident. The register-file write lands on the falling edge inside the `Done` cycle.
- Back-to-back: earliest next start is the cycle after `Done` (IDLE), which requires `Execute` to go low for at least one sampled cycle.

## Configuration
- `REG_CTRL_TRAP_EN` defined: port `Err` exists. `Err` is set on T1 of an illegal opcode, is sticky, and clears on reset or the next accepted start.
- `REG_CTRL_TRAP_EN` undefined: port `Err` is absent. Illegal opcodes complete as 1-cycle NOPs with `Done`.

## Structure
- Package `cpu_pkg` holds:
  - the opcode enum (`OP_LOAD`…`OP_FLIP`);
  - the `AluOp` encodings;
  - the state enum (IDLE, T1, T2);
  - the IR field-position constants.
- Sub-module `instr_decode` (combinational) maps the latched IR to {rx, ry, class LOAD/COPY/ALU/ILLEGAL, aluop}. The FSM and output logic stay in `reg_ctrl_fsm`.

## Test plan
- Reset, then `Execute` 0→1 with IR=10_00_00_0000 (LOAD R2): in T1, `ExtEn`=1, `ENW`=1, `WRA`=2, `Done`=1. Next cycle is IDLE with all outputs 0.
- IR=01_11_00_0001 (COPY R1←R3): T1 gives `ENR0`=1, `RDA0`=3, `WRA`=1, `ENW`=1, `Done`. Latency is 1 cycle.
- IR=00_01_00_0011 (SUB R0−R1): T1 gives `RDA1`=0, `RDA0`=1, `AluOp`=01, `GLd`=1. T2 gives `GEn`=1, `ENW`=1, `WRA`=0, `Done`. `IR` is changed during T1 and the outputs are unaffected.
- Hold `Execute` high across reset and across a full ADD: exactly one instruction executes and no restart occurs until `Execute` goes 0 then 1.
- Assert `RSTb`=0 during T1 of an ADD: the next cycle is IDLE, no `ENW` pulse, no `Done`.
- IR opcode 1010, with and without `REG_CTRL_TRAP_EN`:
  - both builds: `Done` after 1 cycle and no enables;
  - with the macro: `Err`=1 held until the next start.
